// File: rtl/sdram_frame_writer.sv
// rtl/sdram_frame_writer.sv - packs 8-bit camera pixels into 16-bit words for SDRAM write port 1
module sdram_frame_writer #(
    parameter int ASIZE       = 23,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int BASE_ADDR   = 0,
    parameter int LOAD_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             iENABLE,
    input  logic             iFVAL,
    input  logic             iLVAL,
    input  logic [7:0]       iPIX,
    input  logic             iWR_FULL,
    output logic [15:0]      oWR_DATA,
    output logic             oWR,
    output logic             oWR_LOAD,
    output logic [ASIZE-1:0] oWR_ADDR,
    output logic [ASIZE-1:0] oWR_MAX_ADDR,
    output logic             oBUSY,
    output logic             oFRAME_DONE,
    output logic [15:0]      oFRAME_CNT,
    output logic             oOVERFLOW,
    output logic             oSIZE_ERR
);

    localparam int LW = (LOAD_CYCLES < 2) ? 1 : $clog2(LOAD_CYCLES + 1);
    localparam logic [ASIZE-1:0] START_ADDR = ASIZE'(BASE_ADDR);
    localparam logic [ASIZE-1:0] END_ADDR   =
        ASIZE'(BASE_ADDR + ((IMG_WIDTH + 1) / 2) * IMG_HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CAPTURE, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_fval_d;
    logic            r_lval_d;
    logic [LW-1:0]   r_load_cnt;
    logic [15:0]     r_x_cnt;
    logic [15:0]     r_y_cnt;
    logic [7:0]      r_hold;
    logic            r_half;
    logic            r_wr;
    logic [15:0]     r_wr_data;
    logic            r_wr_load;
    logic            r_busy;
    logic            r_frame_done;
    logic [15:0]     r_frame_cnt;
    logic            r_overflow;
    logic            r_size_err;

    logic            w_rise;
    logic            w_pix;
    logic            w_line_end;
    logic            w_load_last;
    logic [15:0]     w_y_eff;
    logic            w_word_rdy;
    logic [15:0]     w_word;

    assign w_rise      = iFVAL & ~r_fval_d;
    assign w_pix       = iFVAL & iLVAL;
    assign w_line_end  = r_lval_d & ~iLVAL;
    assign w_load_last = (r_load_cnt == LW'(LOAD_CYCLES - 1));
    // Line count as it will be after a line ending in this same cycle.
    assign w_y_eff     = r_y_cnt + {15'd0, w_line_end};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_rise && iENABLE) w_next = S_LOAD;
            S_LOAD:    if (w_load_last) w_next = S_CAPTURE;
            S_CAPTURE: if (!iFVAL) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // A word completes either on the odd pixel of a pair or as a padded flush at line end.
    always_comb begin
        w_word_rdy = 1'b0;
        w_word     = 16'h0000;
        if (r_state == S_CAPTURE && r_half) begin
            if (w_pix) begin
                w_word_rdy = 1'b1;
                w_word     = {r_hold, iPIX};
            end else if (w_line_end) begin
                w_word_rdy = 1'b1;
                w_word     = {r_hold, 8'h00};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fval_d     <= 1'b1;
            r_lval_d     <= 1'b0;
            r_load_cnt   <= '0;
            r_x_cnt      <= 16'd0;
            r_y_cnt      <= 16'd0;
            r_hold       <= 8'h00;
            r_half       <= 1'b0;
            r_wr         <= 1'b0;
            r_wr_data    <= 16'h0000;
            r_wr_load    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_overflow   <= 1'b0;
            r_size_err   <= 1'b0;
        end else begin
            r_fval_d     <= iFVAL;
            r_lval_d     <= iLVAL;
            r_wr         <= 1'b0;
            r_wr_load    <= (w_next == S_LOAD);
            r_busy       <= (w_next == S_LOAD) || (w_next == S_CAPTURE);
            r_frame_done <= (w_next == S_DONE);

            if (w_word_rdy) begin
                if (iWR_FULL) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr      <= 1'b1;
                    r_wr_data <= w_word;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise && iENABLE) begin
                        r_overflow <= 1'b0;
                        r_size_err <= 1'b0;
                        r_x_cnt    <= 16'd0;
                        r_y_cnt    <= 16'd0;
                        r_half     <= 1'b0;
                        r_load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_load_cnt <= r_load_cnt + 1'b1;
                    if (w_pix) r_size_err <= 1'b1;
                end
                S_CAPTURE: begin
                    if (w_pix) begin
                        r_x_cnt <= r_x_cnt + 16'd1;
                        if (!r_half) begin
                            r_hold <= iPIX;
                            r_half <= 1'b1;
                        end else begin
                            r_half <= 1'b0;
                        end
                    end
                    if (w_line_end) begin
                        r_half  <= 1'b0;
                        r_x_cnt <= 16'd0;
                        r_y_cnt <= r_y_cnt + 16'd1;
                        if (r_x_cnt != 16'(IMG_WIDTH)) r_size_err <= 1'b1;
                    end
                    if (!iFVAL) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        if (w_y_eff != 16'(IMG_HEIGHT)) r_size_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oWR_DATA     = r_wr_data;
    assign oWR          = r_wr;
    assign oWR_LOAD     = r_wr_load;
    assign oWR_ADDR     = START_ADDR;
    assign oWR_MAX_ADDR = END_ADDR;
    assign oBUSY        = r_busy;
    assign oFRAME_DONE  = r_frame_done;
    assign oFRAME_CNT   = r_frame_cnt;
    assign oOVERFLOW    = r_overflow;
    assign oSIZE_ERR    = r_size_err;

endmodule
